// File: rtl/fft_dma_unloader.sv
// fft_dma_unloader: read-side master for the FFT core output/DMA bus.
// Sweeps dmaa over all bins after a transform, absorbs the core read latency
// with an in-flight valid pipeline, and delivers results on a valid/ready
// stream through a small credit-controlled FIFO.
// Optional feature macro: FFT_UNLOAD_BITREV_EN (bit-reversed read addresses).
//
// state | meaning
// IDLE  | waiting for start, stream quiet
// FETCH | issuing reads while FIFO/in-flight credit allows
// DRAIN | all reads issued, emptying FIFO until the last beat is taken

module fft_dma_unloader #(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW     = 16,
  parameter int RD_LATENCY = 2,
  parameter int FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [7:0]        bfpexp,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     dmaact,
  output logic [FFT_N-1:0]         dmaa,
  input  logic signed [FFT_DW-1:0] dmadr_real,
  input  logic signed [FFT_DW-1:0] dmadr_imag,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [FFT_DW-1:0] m_real,
  output logic signed [FFT_DW-1:0] m_imag,
  output logic [FFT_N-1:0]         m_index,
  output logic                     m_last,
  output logic signed [7:0]        m_bfpexp
);

  localparam int DEPTH = RD_LATENCY + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [FFT_N:0] LAST_IDX = (FFT_N+1)'(FFT_LENGTH - 1);
  localparam logic [CW:0]    DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                   state;
  logic [FFT_N:0]           icnt;
  logic [FFT_N:0]           ocnt;
  logic [RD_LATENCY-1:0]    vpipe;
  logic signed [FFT_DW-1:0] fifo_re [DEPTH];
  logic signed [FFT_DW-1:0] fifo_im [DEPTH];
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            inflight;
  logic [CW:0]              credit_sum;
  logic                     credit_ok;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     accept_last;
  logic [AW-1:0]            wr_idx;

  function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] a);
    logic [FFT_N-1:0] r;
    for (int i = 0; i < FFT_N; i++) r[i] = a[FFT_N-1-i];
    return r;
  endfunction

  // count reads still travelling through the core
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vpipe[i]);
  end

  // a read is only issued if its data is guaranteed a FIFO slot on arrival
  assign credit_sum  = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok   = credit_sum < DEPTH_W;
  assign issue       = (state == FETCH) && credit_ok;
  assign dmaact      = issue;

`ifdef FFT_UNLOAD_BITREV_EN
  assign dmaa = bitrev(icnt[FFT_N-1:0]);
`else
  assign dmaa = icnt[FFT_N-1:0];
`endif

  assign push        = vpipe[RD_LATENCY-1];
  assign m_valid     = (fifo_count != '0);
  assign pop         = m_valid && m_ready;
  assign m_real      = fifo_re[0];
  assign m_imag      = fifo_im[0];
  assign m_index     = ocnt[FFT_N-1:0];
  assign m_last      = (ocnt == LAST_IDX);
  assign accept_last = pop && m_last;
  assign wr_idx      = pop ? AW'(fifo_count - 1'b1) : AW'(fifo_count);

  // sequencing FSM, frame counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      m_bfpexp   <= '0;
      icnt       <= '0;
      ocnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (issue) icnt <= icnt + 1'b1;
      if (pop)   ocnt <= ocnt + 1'b1;
      case (state)
        IDLE: begin
          // a start landing on the frame_done cycle is dropped on purpose
          if (start && !frame_done) begin
            state    <= FETCH;
            busy     <= 1'b1;
            m_bfpexp <= bfpexp;
            icnt     <= '0;
            ocnt     <= '0;
          end
        end
        FETCH: begin
          if (issue && (icnt == LAST_IDX)) state <= DRAIN;
        end
        DRAIN: begin
          if (accept_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in-flight read tracker; the tail marks data arriving this cycle
  always_ff @(posedge clk) begin
    if (rst) vpipe <= '0;
    else     vpipe <= (vpipe << 1) | RD_LATENCY'(issue);
  end

  // shift-register FIFO: entry 0 is the head and drives the stream directly
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_re[i] <= '0;
        fifo_im[i] <= '0;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_re[i] <= fifo_re[i+1];
          fifo_im[i] <= fifo_im[i+1];
        end
      end
      if (push) begin
        fifo_re[wr_idx] <= dmadr_real;
        fifo_im[wr_idx] <= dmadr_imag;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // the credit scheme must make overflow impossible
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && (fifo_count == FULL_CNT)));
  end

endmodule

// File: tb/tb_fft_dma_unloader.sv
// Scoreboard bench for fft_dma_unloader with a small fixed-latency core model
// (real = addr, imag = -addr).
module tb_fft_dma_unloader;

  localparam int L   = 16;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int RDL = 2;

  logic                 clk = 1'b0;
  logic                 rst, start, m_ready;
  logic signed [7:0]    bfpexp;
  logic                 busy, frame_done, dmaact, m_valid, m_last;
  logic [N-1:0]         dmaa, m_index;
  logic signed [DW-1:0] dmadr_real, dmadr_imag, m_real, m_imag;
  logic signed [7:0]    m_bfpexp;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [3:0]         idx;
    logic               last;
    logic signed [7:0]  ex;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    fd_count = 0;
  int    iss = 0;
  logic  prev_stall = 1'b0;
  logic signed [DW-1:0] prev_re, prev_im;
  logic [N-1:0] prev_idx;
  logic [3:0]   apipe [RDL];

  fft_dma_unloader #(.FFT_LENGTH(L), .FFT_DW(DW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .start(start), .bfpexp(bfpexp), .busy(busy),
    .frame_done(frame_done), .dmaact(dmaact), .dmaa(dmaa),
    .dmadr_real(dmadr_real), .dmadr_imag(dmadr_imag), .m_valid(m_valid),
    .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag), .m_index(m_index),
    .m_last(m_last), .m_bfpexp(m_bfpexp)
  );

  always #5 clk = ~clk;

  // core model: address delayed RDL cycles, data presented in cycle t+RDL
  always @(posedge clk) begin
    apipe[0] <= dmaa;
    for (int i = 1; i < RDL; i++) apipe[i] <= apipe[i-1];
  end
  assign dmadr_real = DW'(apipe[RDL-1]);
  assign dmadr_imag = -DW'(apipe[RDL-1]);

  function automatic logic [3:0] br4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  function automatic logic [3:0] addr_of(input int k);
    logic [3:0] a;
    a = 4'(k);
`ifdef FFT_UNLOAD_BITREV_EN
    return br4(a);
`else
    return a;
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic signed [7:0] e);
    beat_t b;
    for (int k = 0; k < L; k++) begin
      b.re   = 16'(addr_of(k));
      b.im   = -16'(addr_of(k));
      b.idx  = 4'(k);
      b.last = (k == L - 1);
      b.ex   = e;
      exp_q.push_back(b);
    end
  endtask

  // leaves the bench at cycle t0+1 (+1 time unit)
  task automatic pulse_start(input logic signed [7:0] e);
    bfpexp = e;
    start  = 1'b1;
    push_frame(e);
    iss      = 0;
    fd_count = 0;
    step();
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ~30% random; 2: 20-cycle stall; 3: ready high with
  // bfpexp change and a stray start mid-frame
  task automatic wait_done(input int mode, output int n, output int fv);
    n  = 1;
    fv = 0;
    while (!frame_done && n < 400) begin
      if (m_valid && fv == 0) fv = n;
      case (mode)
        1: m_ready = ($urandom_range(0, 9) < 3);
        2: m_ready = !(n >= 8 && n < 28);
        default: m_ready = 1'b1;
      endcase
      if (mode == 2 && n == 27) begin
        chk("stall_dmaact_stopped", dmaact, 0);
        chk("stall_valid_held", m_valid, 1);
      end
      if (mode == 3) begin
        start = (n == 6);
        if (n == 6) bfpexp = 8'sd5;
      end
      step();
      n++;
    end
    start = 1'b0;
    if (!frame_done) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_dmaact"}, dmaact, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_dmaa"}, dmaa, 0);
    chk({tag, "_m_index"}, m_index, 0);
    chk({tag, "_m_real"}, m_real, 0);
    chk({tag, "_m_imag"}, m_imag, 0);
    chk({tag, "_m_bfpexp"}, m_bfpexp, 0);
  endtask

  // monitor: scoreboard pops on handshakes, AXI stability, read address order
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_real", m_real, prev_re);
        chk("stall_m_imag", m_imag, prev_im);
        chk("stall_m_index", m_index, prev_idx);
      end
      prev_stall = m_valid && !m_ready;
      prev_re    = m_real;
      prev_im    = m_imag;
      prev_idx   = m_index;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("m_real", m_real, b.re);
          chk("m_imag", m_imag, b.im);
          chk("m_index", m_index, b.idx);
          chk("m_last", m_last, b.last);
          chk("m_bfpexp", m_bfpexp, b.ex);
        end
      end
      if (dmaact) begin
        if (iss >= L) chk("extra_read", iss, L - 1);
        else          chk("dmaa", dmaa, addr_of(iss));
        iss++;
      end
      if (frame_done) fd_count++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fv, k;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; bfpexp = 8'sd0;
    repeat (3) step();
    check_reset("rst_init");
    rst = 1'b0;
    step();

    // basic frame, ready held high
    m_ready = 1'b1;
    pulse_start(8'sd7);
    chk("t1_busy", busy, 1);
    chk("t1_first_dmaact", dmaact, 1);
    chk("t1_first_dmaa", dmaa, 0);
    wait_done(0, n, fv);
    chk("t1_first_valid_cycle", fv, RDL + 2);
    chk("t1_done_cycle", n, L + RDL + 2);
    chk("t1_busy_low_at_done", busy, 0);
    chk("t1_done_count", fd_count, 0);
    step();
    chk("t1_done_pulse_width", frame_done, 0);
    chk("t1_done_count", fd_count, 1);

    // random backpressure
    repeat (2) step();
    pulse_start(-8'sd1);
    wait_done(1, n, fv);
    m_ready = 1'b1;
    step();
    chk("t2_done_count", fd_count, 1);

    // long stall mid-frame
    repeat (2) step();
    pulse_start(8'sd0);
    wait_done(2, n, fv);
    step();
    chk("t3_done_count", fd_count, 1);

    // exponent latch, stray start mid-frame, start on the frame_done cycle
    repeat (2) step();
    pulse_start(-8'sd3);
    wait_done(3, n, fv);
    chk("t4_done_cycle", n, L + RDL + 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_start_on_done_ignored_busy", busy, 0);
    chk("t4_start_on_done_ignored_act", dmaact, 0);
    repeat (3) step();
    chk("t4_still_idle", busy, 0);
    chk("t4_done_count", fd_count, 1);

    // reset while beat 7 is presented
    pulse_start(8'sd2);
    k = 0;
    while (!(m_valid && m_index == 4'd7) && k < 60) begin
      step();
      k++;
    end
    chk("t5_reached_beat7", m_index, 7);
    rst = 1'b1;
    exp_q.delete();
    step();
    check_reset("t5_rst_mid");
    rst = 1'b0;
    iss = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_no_stale_valid", m_valid, 0);
      step();
    end
    pulse_start(8'sd4);
    wait_done(0, n, fv);
    chk("t5_done_cycle", n, L + RDL + 2);
    step();
    chk("t5_done_count", fd_count, 1);

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_dma_unloader.md
# fft_dma_unloader

Read-side master for the FFT core's output/DMA bus. After a transform completes, it sweeps `dmaa` over all `FFT_LENGTH` bins, absorbs the fixed read latency of the core and its RAMs, and presents the results as a valid/ready output stream with backpressure. It sits between the FFT core (`dmaact`/`dmaa`/`dmadr_*`, `bfpexp`) and downstream consumers such as a magnitude unit or an AXI-stream bridge.

## Interface

- `FFT_LENGTH`, 1024: frame length, 2^N.
- `FFT_DW`, 16: sample bitwidth per component.
- `RD_LATENCY`, 2: cycles from `dmaact`/`dmaa` to valid `dmadr_*`. Legal range 1–4.
- `FFT_N`, `$clog2(FFT_LENGTH)`: derived; do not override.

Ports:

- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `start` in 1: single-cycle request to unload one frame. Sampled only in IDLE.
- `bfpexp` in signed 8: block-floating-point exponent from the core. Latched on accepted `start`.
- `busy` out 1: high from accepted `start` until the last beat is accepted.
- `frame_done` out 1: one-cycle pulse on the cycle after the last beat is accepted.
- `dmaact` out 1: read strobe to the core.
- `dmaa` out `FFT_N`: read address to the core.
- `dmadr_real` in signed `FFT_DW`: read data, real component.
- `dmadr_imag` in signed `FFT_DW`: read data, imaginary component.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream ready.
- `m_real` out signed `FFT_DW`: output real component.
- `m_imag` out signed `FFT_DW`: output imaginary component.
- `m_index` out `FFT_N`: bin index of the current beat (0..`FFT_LENGTH`-1, natural order).
- `m_last` out 1: high on the beat with `m_index` = `FFT_LENGTH`-1.
- `m_bfpexp` out signed 8: exponent latched for the current frame.

## Operation

- FSM states:
  - **IDLE**: `start` → FETCH; latch `bfpexp`; clear the issue counter `icnt` and the output counter `ocnt`.
  - **FETCH**: issue reads. When `icnt` reaches `FFT_LENGTH`-1 and that read is issued → DRAIN.
  - **DRAIN**: no new reads. Last beat accepted (`m_valid & m_ready & m_last`) → IDLE, pulse `frame_done`.
- Read issue:
  - `dmaact` = (state == FETCH) & credit_ok.
  - `dmaa` = address derived from `icnt`; `icnt` increments on every issued read.
  - Pipeline: a `RD_LATENCY`-deep valid shift register tracks in-flight reads. When its tail is high, `dmadr_*` is written into the output FIFO.
- Output FIFO:
  - Depth `RD_LATENCY`+2, registered outputs.
  - credit_ok = (fifo_count + inflight_count + issue_this_cycle_accounting) < depth. This guarantees no FIFO overflow under any `m_ready` pattern; overflow must never occur (assertion).
- Beat accounting: `m_index` = `ocnt`; `ocnt` increments on each accepted beat; `m_last` = (`ocnt` == `FFT_LENGTH`-1).
- `start` while busy is ignored. `start` coincident with `frame_done` is also ignored; the requester must wait for IDLE.
- Arithmetic: counters are `FFT_N`+1 bits, with no wrap inside a frame. Data passes through unmodified, with no scaling.
- Reset values:
  - FSM = IDLE.
  - `busy`, `frame_done`, `dmaact`, `m_valid`, `m_last` = 0.
  - `dmaa`, `m_index`, `m_real`, `m_imag` = 0.
  - `m_bfpexp` = 0.
  - FIFO empty, in-flight pipeline cleared.
- `rst` mid-frame aborts immediately. The next cycle shows reset values and in-flight data is discarded.

## Timing

- `start` sampled in cycle t0 → `busy` = 1 and the first `dmaact` (`dmaa` = 0) in cycle t0+1.
- Read issued in cycle t → `dmadr_*` captured at the end of cycle t+`RD_LATENCY` → `m_valid` in cycle t+`RD_LATENCY`+1.
- With `m_ready` held high: one read per cycle, one beat per cycle, no bubbles. A frame takes `FFT_LENGTH`+`RD_LATENCY`+1 cycles from the first `dmaact` to the last beat.
- `m_valid`/data/`m_index`/`m_last` stay stable while `m_valid & !m_ready` (AXI-stream rules).
- `frame_done` occurs the cycle after the last handshake; `busy` falls in the same cycle.

## Configuration

- `FFT_UNLOAD_BITREV_EN` defined: `dmaa` = bit-reverse of `icnt`[`FFT_N`-1:0], so the stream is in natural frequency order when the core stores results bit-reversed. `m_index` is still the natural `ocnt`.
- `FFT_UNLOAD_BITREV_EN` undefined: `dmaa` = `icnt`, a linear sweep.

## Test plan

- `FFT_LENGTH`=16, `RD_LATENCY`=2, core model returns real=addr, imag=−addr, `m_ready`=1, `start` pulse → 16 beats on consecutive cycles, first `m_valid` 4 cycles after `start`, `m_real`=0..15, `m_last` on beat 15, `frame_done` 1 cycle later.
- Same setup with `FFT_UNLOAD_BITREV_EN` → `dmaa` sequence 0,8,4,12,2,…,15; beat k carries `m_real`=bitrev4(k), `m_index`=k.
- Random `m_ready` (~30% duty), `RD_LATENCY`=4 → no loss, no duplication, in-order data, FIFO never overflows, `dmaact` gaps only when credit is exhausted.
- `m_ready`=0 held for 20 cycles mid-frame → `dmaact` stops after the FIFO fills, `m_valid` data stays stable, and the stream resumes intact on release.
- `bfpexp`=−3 at `start`, `bfpexp` changed to 5 mid-frame, plus a second `start` mid-frame → `m_bfpexp`=−3 for all beats, the second `start` is ignored, and exactly one `frame_done` is produced.
- `rst` asserted on beat 7 → next cycle all outputs at reset values. A new `start` then produces a complete frame from index 0.
